// File: rtl/hazard_pkg.sv
// Shared defaults and field helpers for the hazard controller and its scoreboard.
package hazard_pkg;

    localparam int unsigned NSTAGE_DEF  = 7;
    localparam int unsigned NISSUE_DEF  = 2;
    localparam int unsigned NREG_DEF    = 32;
    localparam int unsigned LATW_DEF    = 3;
    localparam int unsigned DS_IDX_DEF  = 2;
    localparam int unsigned ES_IDX_DEF  = 3;
    localparam int unsigned EXC_IDX_DEF = 5;
    localparam int unsigned REGW        = 5;

    // Bit offset of source k of slot s inside the packed ds_rs bus.
    function automatic int unsigned src_lsb(input int unsigned slot, input int unsigned k);
        return (2 * slot + k) * REGW;
    endfunction

    // Bit offset of the destination register of slot s inside ds_rd.
    function automatic int unsigned rd_lsb(input int unsigned slot);
        return slot * REGW;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: counts down cycles until each GPR result is
// forwardable to ds and flags read-after-write hazards for the ds bundle.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NISSUE = NISSUE_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned LATW   = LATW_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NISSUE-1:0]        ds_valid,
    input  logic [NISSUE*2*REGW-1:0] ds_rs,
    input  logic [NISSUE*REGW-1:0]   ds_rd,
    input  logic [NISSUE-1:0]        ds_we,
    input  logic [NISSUE*LATW-1:0]   ds_lat,
    input  logic                     issue_i,
    input  logic                     kill_i,
    input  logic                     hold_i,
    output logic                     raw_hit_c
);

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];

    // Any valid slot reading a register whose producer is still in flight.
    always_comb begin
        raw_hit_c = 1'b0;
        for (int s = 0; s < NISSUE; s++) begin
            for (int k = 0; k < 2; k++) begin
                if (ds_valid[s] && (ds_rs[src_lsb(s, k) +: REGW] != '0) &&
                    (cnt_q[ds_rs[src_lsb(s, k) +: REGW]] != '0)) begin
                    raw_hit_c = 1'b1;
                end
            end
        end
    end

    // Slots are visited oldest first so the younger slot's write lands last.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (kill_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end else if (!hold_i) begin
            for (int r = 1; r < NREG; r++) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LATW'(1);
                end
            end
            for (int s = 0; s < NISSUE; s++) begin
                if (issue_i && ds_valid[s] && ds_we[s] && (ds_rd[rd_lsb(s) +: REGW] != '0)) begin
                    cnt_d[ds_rd[rd_lsb(s) +: REGW]] = ds_lat[s*LATW +: LATW];
                end
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: resolves kill / multi-cycle / RAW / mispredict
// priority into per-stage stall and flush vectors and counts RAW stall cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE  = NSTAGE_DEF,
    parameter int unsigned NISSUE  = NISSUE_DEF,
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned LATW    = LATW_DEF,
    parameter int unsigned DS_IDX  = DS_IDX_DEF,
    parameter int unsigned ES_IDX  = ES_IDX_DEF,
    parameter int unsigned EXC_IDX = EXC_IDX_DEF,
    // Largest ds_lat the datapath may present; bounded by the front-end refill depth.
    parameter int unsigned MAX_LAT = DS_IDX_DEF + 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NISSUE-1:0]        ds_valid,
    input  logic [NISSUE*2*REGW-1:0] ds_rs,
    input  logic [NISSUE*REGW-1:0]   ds_rd,
    input  logic [NISSUE-1:0]        ds_we,
    input  logic [NISSUE*LATW-1:0]   ds_lat,
    input  logic                     mc_busy,
    input  logic                     br_prd_err,
    input  logic                     exc_req,
    input  logic                     eret_req,
    output logic [NSTAGE-1:0]        stall,
    output logic [NSTAGE-1:0]        flush,
    output logic                     ds_issue,
    output logic [31:0]              raw_stall_cnt
);

    // Clearing the scoreboard on kill is only safe if no producer outlives the refill.
    if ((MAX_LAT > DS_IDX + 1) || (MAX_LAT > (1 << LATW) - 1)) begin : g_lat_chk
        $error("hazard_ctrl: MAX_LAT exceeds refill depth or counter range");
    end
    if ((EXC_IDX + 1 >= NSTAGE) || (ES_IDX <= DS_IDX) || (EXC_IDX <= ES_IDX)) begin : g_idx_chk
        $error("hazard_ctrl: inconsistent stage indices");
    end

    logic        kill_c;
    logic        raw_hit_c;
    logic [31:0] raw_stall_cnt_q;
    logic [31:0] raw_stall_cnt_d;

    assign kill_c = exc_req | eret_req;

    hazard_scoreboard #(
        .NISSUE (NISSUE),
        .NREG   (NREG),
        .LATW   (LATW)
    ) u_scoreboard (
        .clk       (clk),
        .resetn    (resetn),
        .ds_valid  (ds_valid),
        .ds_rs     (ds_rs),
        .ds_rd     (ds_rd),
        .ds_we     (ds_we),
        .ds_lat    (ds_lat),
        .issue_i   (ds_issue),
        .kill_i    (kill_c),
        .hold_i    (mc_busy),
        .raw_hit_c (raw_hit_c)
    );

    // Priority: kill > mc_busy > raw_hit > br_prd_err (mispredict overrides the front stall).
    always_comb begin
        stall = '0;
        flush = '0;
        if (kill_c) begin
            for (int unsigned i = 0; i <= EXC_IDX; i++) begin
                flush[i] = 1'b1;
            end
            flush[EXC_IDX+1] = exc_req;
        end else if (mc_busy) begin
            for (int unsigned i = 0; i <= ES_IDX; i++) begin
                stall[i] = 1'b1;
            end
            flush[ES_IDX+1] = 1'b1;
        end else begin
            if (raw_hit_c) begin
                for (int unsigned i = 0; i <= DS_IDX; i++) begin
                    stall[i] = 1'b1;
                end
                flush[ES_IDX] = 1'b1;
            end
            if (br_prd_err) begin
                for (int unsigned i = 0; i <= DS_IDX; i++) begin
                    stall[i] = 1'b0;
                    flush[i] = 1'b1;
                end
            end
        end
    end

    assign ds_issue = (|ds_valid) & ~stall[DS_IDX] & ~flush[DS_IDX];

    always_comb begin
        raw_stall_cnt_d = raw_stall_cnt_q;
        if (raw_hit_c && !kill_c && !mc_busy && (raw_stall_cnt_q != '1)) begin
            raw_stall_cnt_d = raw_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            raw_stall_cnt_q <= '0;
        end else begin
            raw_stall_cnt_q <= raw_stall_cnt_d;
        end
    end

    assign raw_stall_cnt = raw_stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl: a ready-time reference model feeds
// an expected-response queue that a negedge monitor drains and compares.
module tb_hazard_ctrl;

    typedef struct {
        logic [1:0]  v;
        logic [19:0] rs;
        logic [9:0]  rd;
        logic [1:0]  we;
        logic [5:0]  lat;
        logic        mc;
        logic        br;
        logic        exc;
        logic        eret;
    } stim_t;

    typedef struct {
        logic [6:0]  stall;
        logic [6:0]  flush;
        logic        issue;
        logic [31:0] rcnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  ds_valid;
    logic [19:0] ds_rs;
    logic [9:0]  ds_rd;
    logic [1:0]  ds_we;
    logic [5:0]  ds_lat;
    logic        mc_busy, br_prd_err, exc_req, eret_req;
    logic [6:0]  stall, flush;
    logic        ds_issue;
    logic [31:0] raw_stall_cnt;

    hazard_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .ds_valid      (ds_valid),
        .ds_rs         (ds_rs),
        .ds_rd         (ds_rd),
        .ds_we         (ds_we),
        .ds_lat        (ds_lat),
        .mc_busy       (mc_busy),
        .br_prd_err    (br_prd_err),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .stall         (stall),
        .flush         (flush),
        .ds_issue      (ds_issue),
        .raw_stall_cnt (raw_stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a register is ready once enough non-held cycles have elapsed.
    longint prog;
    longint ready_at [32];
    int     model_rcnt;
    exp_t   exp_q [$];
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("flush", 32'(flush), 32'(e.flush));
            chk("ds_issue", 32'(ds_issue), 32'(e.issue));
            chk("raw_stall_cnt", raw_stall_cnt, e.rcnt);
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s.v = '0; s.rs = '0; s.rd = '0; s.we = '0; s.lat = '0;
        s.mc = 1'b0; s.br = 1'b0; s.exc = 1'b0; s.eret = 1'b0;
        return s;
    endfunction

    function automatic stim_t rd_op(input stim_t s, input int slot, input int src, input int rg);
        stim_t o;
        o = s;
        o.v[slot] = 1'b1;
        o.rs[(2*slot+src)*5 +: 5] = 5'(rg);
        return o;
    endfunction

    function automatic stim_t wr_op(input stim_t s, input int slot, input int rg, input int l);
        stim_t o;
        o = s;
        o.v[slot] = 1'b1;
        o.we[slot] = 1'b1;
        o.rd[slot*5 +: 5] = 5'(rg);
        o.lat[slot*3 +: 3] = 3'(l);
        return o;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
    endfunction

    task automatic drive(input stim_t s);
        ds_valid = s.v; ds_rs = s.rs; ds_rd = s.rd; ds_we = s.we; ds_lat = s.lat;
        mc_busy = s.mc; br_prd_err = s.br; exc_req = s.exc; eret_req = s.eret;
    endtask

    // Apply one cycle of stimulus, queue the expected response, then advance the model.
    task automatic cycle(input stim_t s);
        exp_t e;
        bit   hit, kill, iss;
        int   rg;
        @(posedge clk);
        #1;
        drive(s);
        hit = 1'b0;
        for (int sl = 0; sl < 2; sl++)
            for (int k = 0; k < 2; k++) begin
                rg = int'(s.rs[(2*sl+k)*5 +: 5]);
                if (s.v[sl] && rg != 0 && ready_at[rg] > prog) hit = 1'b1;
            end
        kill = s.exc | s.eret;
        e.rcnt = 32'(model_rcnt);
        if (kill) begin
            e.stall = 7'h00;
            e.flush = s.exc ? 7'h7F : 7'h3F;
            iss = 1'b0;
        end else if (s.mc) begin
            e.stall = 7'h0F;
            e.flush = 7'h10;
            iss = 1'b0;
        end else begin
            e.stall = hit ? 7'h07 : 7'h00;
            e.flush = hit ? 7'h08 : 7'h00;
            if (s.br) begin
                e.stall = 7'h00;
                e.flush = e.flush | 7'h07;
            end
            iss = (s.v != 0) && !hit && !s.br;
        end
        e.issue = iss;
        exp_q.push_back(e);
        if (kill) begin
            model_clear();
        end else if (!s.mc) begin
            if (hit) model_rcnt++;
            if (iss)
                for (int sl = 0; sl < 2; sl++) begin
                    rg = int'(s.rd[sl*5 +: 5]);
                    if (s.v[sl] && s.we[sl] && rg != 0)
                        ready_at[rg] = prog + 1 + longint'(s.lat[sl*3 +: 3]);
                end
            prog++;
        end
    endtask

    task automatic mid_reset();
        exp_t e;
        @(posedge clk);
        #1;
        drive(idle());
        resetn = 1'b0;
        model_clear();
        model_rcnt = 0;
        e.stall = '0; e.flush = '0; e.issue = 1'b0; e.rcnt = '0;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        stim_t s;
        exp_t  e0;
        prog = 0;
        model_rcnt = 0;
        model_clear();
        resetn = 1'b0;
        drive(idle());
        e0.stall = '0; e0.flush = '0; e0.issue = 1'b0; e0.rcnt = '0;
        exp_q.push_back(e0);
        @(negedge clk);
        #1;
        resetn = 1'b1;

        // load r5 lat 2, then dependent reader
        cycle(wr_op(idle(), 0, 5, 2));
        repeat (3) cycle(rd_op(idle(), 0, 0, 5));
        cycle(idle());

        // both slots write r7; younger slot's latency 3 wins
        s = wr_op(idle(), 0, 7, 1);
        s = wr_op(s, 1, 7, 3);
        cycle(s);
        repeat (4) cycle(rd_op(idle(), 1, 1, 7));

        // r3 pending at 2 held across a 4-cycle mc_busy
        cycle(wr_op(idle(), 0, 3, 3));
        cycle(idle());
        s = idle(); s.mc = 1'b1;
        repeat (4) cycle(rd_op(s, 0, 0, 3));
        repeat (3) cycle(rd_op(idle(), 0, 0, 3));

        // exception and eret with scoreboard busy
        cycle(wr_op(idle(), 0, 9, 3));
        s = rd_op(idle(), 0, 0, 9); s.exc = 1'b1;
        cycle(s);
        cycle(rd_op(idle(), 0, 0, 9));
        cycle(wr_op(idle(), 1, 10, 2));
        s = rd_op(idle(), 0, 1, 10); s.eret = 1'b1;
        cycle(s);
        cycle(rd_op(idle(), 0, 1, 10));

        // mispredict concurrent with a RAW hit
        cycle(wr_op(idle(), 0, 12, 3));
        s = rd_op(idle(), 0, 0, 12); s.br = 1'b1;
        cycle(s);
        repeat (3) cycle(rd_op(idle(), 0, 0, 12));

        // r0 is never tracked
        cycle(wr_op(idle(), 0, 0, 3));
        cycle(rd_op(rd_op(idle(), 0, 0, 0), 1, 1, 0));

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                cycle(wr_op(idle(), 0, 4, 3));
                mid_reset();
                cycle(rd_op(idle(), 0, 0, 4));
            end
            s = idle();
            for (int sl = 0; sl < 2; sl++) begin
                s.v[sl] = 1'($urandom_range(0, 3) != 0);
                s.we[sl] = 1'($urandom_range(0, 1));
                s.rd[sl*5 +: 5] = 5'($urandom_range(0, 7));
                s.lat[sl*3 +: 3] = 3'($urandom_range(0, 3));
                for (int k = 0; k < 2; k++)
                    s.rs[(2*sl+k)*5 +: 5] = 5'($urandom_range(0, 7));
            end
            s.mc   = 1'($urandom_range(0, 9) == 0);
            s.br   = 1'($urandom_range(0, 9) == 0);
            s.exc  = 1'($urandom_range(0, 39) == 0);
            s.eret = 1'($urandom_range(0, 39) == 0);
            cycle(s);
        end
        cycle(idle());
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
